// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit with accumulator chaining and result reduction flags
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor,
  output logic             zero,
  output logic [WIDTH-1:0] acc_q
);
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s1_acc_en_q, s1_acc_en_d;
  logic             s1_acc_clr_q, s1_acc_clr_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             red_and_q, red_and_d;
  logic             red_or_q, red_or_d;
  logic             red_xor_q, red_xor_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_d;
  logic             s1_load, s2_load;
  logic [WIDTH-1:0] opa, res;

  always_comb begin
    s2_load    = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready   = ~s1_valid_q | s2_load;
    s1_load    = in_valid & in_ready;
    s1_valid_d = s1_load | (s1_valid_q & ~s2_load);
    s2_valid_d = s2_load | (s2_valid_q & ~out_ready);
  end

  always_comb begin
    s1_op_d      = s1_load ? op      : s1_op_q;
    s1_acc_en_d  = s1_load ? acc_en  : s1_acc_en_q;
    s1_acc_clr_d = s1_load ? acc_clr : s1_acc_clr_q;
    s1_a_d       = s1_load ? a       : s1_a_q;
    s1_b_d       = s1_load ? b       : s1_b_q;
  end

  // Accumulator is read here, after any earlier acc result has already been written back.
  always_comb begin
    opa = s1_acc_en_q ? (s1_acc_clr_q ? '0 : acc_q) : s1_a_q;
    res = '0;
    case (s1_op_q)
      3'd0: res = opa & s1_b_q;
      3'd1: res = opa | s1_b_q;
      3'd2: res = ~opa;
      3'd3: res = ~(opa & s1_b_q);
      3'd4: res = ~(opa | s1_b_q);
      3'd5: res = opa ^ s1_b_q;
      3'd6: res = ~(opa ^ s1_b_q);
      default: res = s1_b_q;
    endcase
  end

  always_comb begin
    y_d       = s2_load ? res : y_q;
    red_and_d = s2_load ? &res : red_and_q;
    red_or_d  = s2_load ? |res : red_or_q;
    red_xor_d = s2_load ? ^res : red_xor_q;
    zero_d    = s2_load ? ~|res : zero_q;
    acc_d     = (s2_load & s1_acc_en_q) ? res : acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_acc_en_q  <= 1'b0;
      s1_acc_clr_q <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s2_valid_q   <= 1'b0;
      y_q          <= '0;
      red_and_q    <= 1'b0;
      red_or_q     <= 1'b0;
      red_xor_q    <= 1'b0;
      zero_q       <= 1'b0;
      acc_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_acc_en_q  <= s1_acc_en_d;
      s1_acc_clr_q <= s1_acc_clr_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      y_q          <= y_d;
      red_and_q    <= red_and_d;
      red_or_q     <= red_or_d;
      red_xor_q    <= red_xor_d;
      zero_q       <= zero_d;
      acc_q        <= acc_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign red_and   = red_and_q;
  assign red_or    = red_or_q;
  assign red_xor   = red_xor_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and random checks of logic_unit_pipe against an in-order transaction model
module tb_logic_unit_pipe;
  logic       clk = 0, rst = 0;
  logic       in_valid = 0, in_ready, acc_en = 0, acc_clr = 0;
  logic [2:0] op = 0;
  logic [7:0] a = 0, b = 0, y, acc_q;
  logic       out_valid, out_ready = 1;
  logic       red_and, red_or, red_xor, zero;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .red_and(red_and), .red_or(red_or),
    .red_xor(red_xor), .zero(zero), .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] y; logic [7:0] acc; int cyc; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] got_y[$];
  logic [3:0] got_f[$];
  logic [7:0] macc = 0;
  int         checks = 0, errors = 0, cyc = 0;
  logic       accepted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~x;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return x ^ z;
      3'd6: return ~(x ^ z);
      default: return z;
    endcase
  endfunction

  // Results are computed in acceptance order, so the model accumulator is always current.
  task automatic model_push();
    exp_t e;
    logic [7:0] ea;
    ea = acc_en ? (acc_clr ? 8'h00 : macc) : a;
    e.y = ref_op(op, ea, b);
    if (acc_en) macc = e.y;
    e.acc = macc;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    #1;
    chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
    chk("out_valid", out_valid, (exp_q.size() > 0) ? (exp_q[0].cyc <= cyc - 2) : 1'b0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("y", y, e.y);
        chk("acc_q", acc_q, e.acc);
        chk("red_and", red_and, &e.y);
        chk("red_or", red_or, |e.y);
        chk("red_xor", red_xor, ^e.y);
        chk("zero", zero, e.y == 8'h00);
        got_y.push_back(y);
        got_f.push_back({zero, red_and, red_or, red_xor});
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) model_push();
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [2:0] o, input logic ae, input logic ac, input logic [7:0] x, input logic [7:0] z);
    int n = 0;
    op = o; acc_en = ae; acc_clr = ac; a = x; b = z; in_valid = 1;
    do begin step(); n++; end while (!accepted && n < 50);
    if (!accepted) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0; out_ready = 1;
    while (exp_q.size() > 0 && n < 20) begin step(); n++; end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    #2 rst = 1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_acc_q", acc_q, 0);
    chk("rst_in_ready", in_ready, 1);
    exp_q.delete();
    macc = 0;
    @(negedge clk);
    rst = 0;
    cyc++;
  endtask

  task automatic cmp_list(input string tag, input logic [7:0] l [4], input int n);
    chk({tag, "_count"}, got_y.size(), n);
    for (int i = 0; i < n && i < got_y.size(); i++) chk(tag, got_y[i], l[i]);
  endtask

  initial begin
    logic [7:0] opsx [8] = '{8'hC0, 8'hFA, 8'h35, 8'h3F, 8'h05, 8'h3A, 8'hC5, 8'hF0};
    logic [7:0] accx [4] = '{8'h0F, 8'hF0, 8'h30, 8'h01};
    logic [7:0] bpx  [4] = '{8'hC0, 8'hFA, 8'h3A, 8'h00};
    logic [7:0] rstx [4] = '{8'hFF, 8'h00, 8'h00, 8'h00};
    @(negedge clk);
    in_valid = 1; op = 3'd5; a = 8'h5A; b = 8'hA5; acc_en = 1;
    do_reset();
    in_valid = 0; acc_en = 0;
    repeat (2) step();

    got_y.delete();
    out_ready = 1;
    for (int i = 0; i < 8; i++) send(3'(i), 0, 0, 8'hCA, 8'hF0);
    drain();
    for (int i = 0; i < 8; i++) chk("ops_y", (got_y.size() > i) ? got_y[i] : 8'hxx, opsx[i]);

    got_y.delete();
    out_ready = 0;
    send(3'd0, 0, 0, 8'hCA, 8'hF0);
    send(3'd1, 0, 0, 8'hCA, 8'hF0);
    op = 3'd5; in_valid = 1;
    repeat (4) begin step(); chk("bp_held", accepted, 0); end
    chk("bp_inflight", exp_q.size(), 2);
    out_ready = 1;
    step();
    chk("bp_release_accept", accepted, 1);
    drain();
    cmp_list("bp_y", bpx, 3);

    got_y.delete();
    send(3'd1, 1, 1, 8'h00, 8'h0F);
    send(3'd5, 1, 0, 8'h00, 8'hFF);
    send(3'd0, 1, 0, 8'h00, 8'h3C);
    send(3'd0, 0, 0, 8'hFF, 8'h01);
    drain();
    cmp_list("acc_y", accx, 4);
    chk("acc_final", acc_q, 8'h30);

    got_f.delete();
    send(3'd7, 0, 0, 8'h00, 8'h00);
    send(3'd7, 0, 0, 8'h00, 8'hFF);
    send(3'd7, 0, 0, 8'h00, 8'h07);
    drain();
    chk("flags_00", (got_f.size() > 0) ? got_f[0] : 4'hx, 4'b1000);
    chk("flags_ff", (got_f.size() > 1) ? got_f[1] : 4'hx, 4'b0110);
    chk("flags_07", (got_f.size() > 2) ? got_f[2] : 4'hx, 4'b0011);

    send(3'd7, 1, 0, 8'h00, 8'h55);
    drain();
    out_ready = 0;
    send(3'd1, 0, 0, 8'h12, 8'h34);
    send(3'd2, 0, 0, 8'h12, 8'h34);
    in_valid = 0;
    chk("mid_acc_pre", acc_q, 8'h55);
    do_reset();
    out_ready = 1;
    got_y.delete();
    send(3'd5, 1, 0, 8'h00, 8'hFF);
    drain();
    cmp_list("post_rst_y", rstx, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      op        = 3'($urandom_range(0, 7));
      acc_en    = $urandom_range(0, 2) == 0;
      acc_clr   = $urandom_range(0, 3) == 0;
      a         = 8'($urandom);
      b         = 8'($urandom);
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
